// File: rtl/count_checker.sv
// Observes a free-running counter bus, predicts its next value, tracks lock and tallies violations.
// Latency 1: every output is registered on the edge that accepts a sample (sample_en=1).
// No backpressure: a sample is consumed whenever sample_en=1. Optional macro: COUNT_CHECKER_HOLD_EN.
module count_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 sample_en,
    input  logic                 dir,
    output logic                 locked,
    output logic                 mismatch,
    output logic                 wrap,
    output logic [WIDTH-1:0]     expected,
    output logic [ERR_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]     ALL_ONES = '1;
    localparam logic [3:0]           LOCK_TGT = 4'(LOCK_COUNT);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX  = '1;

    state_t          state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       match_cnt;

    logic [WIDTH-1:0] pred;
    logic [WIDTH-1:0] next_exp;
    logic             hit;
    logic             stalled;
    logic             at_wrap;

    always_comb begin
        pred     = dir ? (prev - ONE) : (prev + ONE);
        next_exp = dir ? (count_in - ONE) : (count_in + ONE);
        hit      = (count_in == pred);
        at_wrap  = dir ? (count_in == ALL_ONES) : (count_in == '0);
`ifdef COUNT_CHECKER_HOLD_EN
        // A stalled counter neither advances nor breaks lock.
        stalled  = (count_in == prev);
`else
        stalled  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prev      <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
            wrap      <= 1'b0;
            expected  <= '0;
            err_count <= '0;
        end else begin
            mismatch <= 1'b0;
            wrap     <= 1'b0;
            if (sample_en && !stalled) begin
                prev     <= count_in;
                expected <= next_exp;
                case (state)
                    IDLE: begin
                        state     <= ACQUIRE;
                        match_cnt <= '0;
                    end
                    ACQUIRE: begin
                        if (hit) begin
                            match_cnt <= match_cnt + 4'd1;
                            if ((match_cnt + 4'd1) == LOCK_TGT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            wrap <= at_wrap;
                        end else begin
                            // Resynchronise from the offending value rather than the prediction.
                            mismatch  <= 1'b1;
                            locked    <= 1'b0;
                            state     <= ACQUIRE;
                            match_cnt <= '0;
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        match_cnt <= '0;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed scenarios plus randomized traffic against a history-based model.
module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count_in = '0;
    logic       sample_en = 1'b0;
    logic       dir = 1'b0;

    logic       locked, mismatch, wrap;
    logic [3:0] expected;
    logic [7:0] err_count;
    logic       locked2, mismatch2, wrap2;
    logic [3:0] expected2;
    logic [1:0] err_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_checker #(.WIDTH(4), .LOCK_COUNT(2), .ERR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .dir(dir),
        .locked(locked), .mismatch(mismatch), .wrap(wrap), .expected(expected), .err_count(err_count)
    );

    count_checker #(.WIDTH(4), .LOCK_COUNT(2), .ERR_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .dir(dir),
        .locked(locked2), .mismatch(mismatch2), .wrap(wrap2), .expected(expected2), .err_count(err_count2)
    );

    // Reference model: phase 0 = not started, 1 = searching, 2 = tracking.
    int m_phase, m_prev, m_run, m_exp, m_err, m_err2;
    bit m_locked, m_mismatch, m_wrap;

    function automatic void model_update(input bit r, input bit en, input bit d, input int v);
        int step_v, pred;
        step_v = d ? 15 : 1;
        if (r) begin
            m_phase = 0; m_prev = 0; m_run = 0; m_exp = 0; m_err = 0; m_err2 = 0;
            m_locked = 0; m_mismatch = 0; m_wrap = 0;
            return;
        end
        m_mismatch = 0;
        m_wrap = 0;
        if (!en) return;
`ifdef COUNT_CHECKER_HOLD_EN
        if (v == m_prev) return;
`endif
        pred = (m_prev + step_v) % 16;
        if (m_phase == 0) begin
            m_phase = 1; m_run = 0;
        end else if (m_phase == 1) begin
            if (v == pred) begin
                m_run++;
                if (m_run == 2) begin m_phase = 2; m_locked = 1; end
            end else m_run = 0;
        end else begin
            if (v == pred) m_wrap = d ? (v == 15) : (v == 0);
            else begin
                m_mismatch = 1; m_locked = 0; m_phase = 1; m_run = 0;
                m_err  = (m_err  < 255) ? m_err + 1 : 255;
                m_err2 = (m_err2 < 3)   ? m_err2 + 1 : 3;
            end
        end
        m_prev = v;
        m_exp  = (v + step_v) % 16;
    endfunction

    task automatic step(input bit r, input bit en, input bit d, input int v);
        rst = r; sample_en = en; dir = d; count_in = 4'(v % 16);
        @(posedge clk);
        model_update(r, en, d, v % 16);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 9);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset.locked got=%0d want=0", locked); end
        checks++; if (mismatch !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL reset.pulses got=%0b%0b want=00", mismatch, wrap); end
        checks++; if (expected !== 4'd0) begin errors++; $display("FAIL reset.expected got=%0d want=0", expected); end
        checks++; if (err_count !== 8'd0 || err_count2 !== 2'd0) begin errors++; $display("FAIL reset.err_count got=%0d/%0d want=0", err_count, err_count2); end
    endtask

    task automatic test_lock_up();
        step(0, 1, 0, 0);
        checks++; if (locked !== 1'b0 || expected !== 4'd1) begin errors++; $display("FAIL lock_up.first got=%0d,%0d want=0,1", locked, expected); end
        step(0, 1, 0, 1);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_up.early got=%0d want=0", locked); end
        step(0, 1, 0, 2);
        checks++; if (locked !== 1'b1 || expected !== 4'd3 || err_count !== 8'd0) begin
            errors++; $display("FAIL lock_up.locked got=%0d,%0d,%0d want=1,3,0", locked, expected, err_count); end
    endtask

    task automatic test_wrap_up();
        for (int v = 3; v <= 14; v++) step(0, 1, 0, v);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_up.at14 got=%0d want=0", wrap); end
        step(0, 1, 0, 15);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_up.at15 got=%0d want=0", wrap); end
        step(0, 1, 0, 0);
        checks++; if (wrap !== 1'b1 || mismatch !== 1'b0 || expected !== 4'd1 || locked !== 1'b1) begin
            errors++; $display("FAIL wrap_up.at0 got=%0b%0b,%0d,%0b want=10,1,1", wrap, mismatch, expected, locked); end
        step(0, 0, 0, 0);
        checks++; if (wrap !== 1'b0 || expected !== 4'd1) begin errors++; $display("FAIL wrap_up.drop got=%0d,%0d want=0,1", wrap, expected); end
    endtask

    task automatic test_error_relock();
        for (int v = 1; v <= 5; v++) step(0, 1, 0, v);
        step(0, 1, 0, 9);
        checks++; if (mismatch !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || expected !== 4'd10) begin
            errors++; $display("FAIL error.hit got=%0d,%0d,%0d,%0d want=1,1,0,10", mismatch, err_count, locked, expected); end
        step(0, 0, 0, 3);
        checks++; if (mismatch !== 1'b0 || err_count !== 8'd1) begin errors++; $display("FAIL error.pulse got=%0d,%0d want=0,1", mismatch, err_count); end
        step(0, 1, 0, 10);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL error.relock_early got=%0d want=0", locked); end
        step(0, 1, 0, 11);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL error.relock got=%0d want=1", locked); end
    endtask

    task automatic test_down();
        step(1, 0, 0, 0);
        step(0, 1, 1, 3);
        step(0, 1, 1, 2);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL down.early got=%0d want=0", locked); end
        step(0, 1, 1, 1);
        checks++; if (locked !== 1'b1 || expected !== 4'd0) begin errors++; $display("FAIL down.lock got=%0d,%0d want=1,0", locked, expected); end
        step(0, 1, 1, 0);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down.at0 got=%0d want=0", wrap); end
        step(0, 1, 1, 15);
        checks++; if (wrap !== 1'b1 || expected !== 4'd14 || mismatch !== 1'b0) begin
            errors++; $display("FAIL down.wrap got=%0d,%0d,%0d want=1,14,0", wrap, expected, mismatch); end
    endtask

    task automatic test_saturation();
        int v;
        step(1, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 2);
        v = 2;
        for (int k = 0; k < 4; k++) begin
            v = (v + 5) % 16;
            step(0, 1, 0, v);
            checks++; if (err_count2 !== 2'((k < 3) ? k + 1 : 3) || err_count !== 8'(k + 1)) begin
                errors++; $display("FAIL sat.err%0d got=%0d,%0d want=%0d,%0d", k, err_count2, err_count, (k < 3) ? k + 1 : 3, k + 1); end
            v = (v + 1) % 16; step(0, 1, 0, v);
            v = (v + 1) % 16; step(0, 1, 0, v);
            checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL sat.relock%0d got=%0d want=1", k, locked2); end
        end
    endtask

    task automatic test_reset_locked();
        step(1, 1, 0, 5);
        checks++; if ({locked, mismatch, wrap} !== 3'b000 || expected !== 4'd0 || err_count !== 8'd0 || err_count2 !== 2'd0) begin
            errors++; $display("FAIL rst_locked.outs got=%0b%0b%0b,%0d,%0d want=000,0,0", locked, mismatch, wrap, expected, err_count); end
        step(0, 1, 0, 9);
        checks++; if (locked !== 1'b0 || mismatch !== 1'b0 || expected !== 4'd10) begin
            errors++; $display("FAIL rst_locked.idle got=%0d,%0d,%0d want=0,0,10", locked, mismatch, expected); end
        step(0, 1, 0, 10);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked.acq got=%0d want=0", locked); end
    endtask

    task automatic test_hold();
        step(1, 0, 0, 0);
        step(0, 1, 0, 5); step(0, 1, 0, 6); step(0, 1, 0, 7);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hold.lock got=%0d want=1", locked); end
        step(0, 1, 0, 7);
`ifdef COUNT_CHECKER_HOLD_EN
        checks++; if (mismatch !== 1'b0 || locked !== 1'b1 || expected !== 4'd8 || err_count !== 8'd0) begin
            errors++; $display("FAIL hold.repeat got=%0d,%0d,%0d,%0d want=0,1,8,0", mismatch, locked, expected, err_count); end
`else
        checks++; if (mismatch !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
            errors++; $display("FAIL hold.repeat got=%0d,%0d,%0d want=1,0,1", mismatch, locked, err_count); end
`endif
    endtask

    task automatic test_random();
        bit d = 0;
        for (int i = 0; i < 600; i++) begin
            int sel, v;
            bit r, en;
            if ($urandom_range(0, 19) == 0) d = ~d;
            r   = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 9);
            if (sel < 7)      v = m_phase == 0 ? $urandom_range(0, 15) : (m_prev + (d ? 15 : 1)) % 16;
            else if (sel < 8) v = m_prev;
            else              v = $urandom_range(0, 15);
            step(r, en, d, v);
            checks++; if (locked !== m_locked) begin errors++; $display("FAIL rand%0d.locked got=%0d want=%0d", i, locked, m_locked); end
            checks++; if (mismatch !== m_mismatch) begin errors++; $display("FAIL rand%0d.mismatch got=%0d want=%0d", i, mismatch, m_mismatch); end
            checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL rand%0d.wrap got=%0d want=%0d", i, wrap, m_wrap); end
            checks++; if (expected !== 4'(m_exp)) begin errors++; $display("FAIL rand%0d.expected got=%0d want=%0d", i, expected, m_exp); end
            checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL rand%0d.err_count got=%0d want=%0d", i, err_count, m_err); end
            checks++; if (err_count2 !== 2'(m_err2)) begin errors++; $display("FAIL rand%0d.err_sat got=%0d want=%0d", i, err_count2, m_err2); end
        end
    endtask

    initial begin
        model_update(1, 0, 0, 0);
        test_reset();
        test_lock_up();
        test_wrap_up();
        test_error_relock();
        test_down();
        test_saturation();
        test_reset_locked();
        test_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Hardware-side consumer of a free-running WIDTH-bit counter output. It observes the count stream, predicts the next value, and flags sequence violations.
- It is the observing end of the counter/tester pairing: the tester drives clk/rst, and this block judges the counter's out bus.
- Works in up or down mode, tracks lock via a small FSM, and keeps a saturating error tally. Intended for in-bench and on-board self-check of ripple counters.

Parameters:
- WIDTH, 4, width of observed count bus.
- LOCK_COUNT, 2, consecutive correct transitions required to enter LOCKED (1..15).
- ERR_WIDTH, 8, width of saturating error counter.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  reset: synchronous, active-high.
- count_in  input  WIDTH  observed counter value.
- sample_en  input  1  count_in is valid this cycle.
- dir  input  1  expected direction: 0 = up, 1 = down; sampled with count_in.
- locked  output  1  sequence is tracking correctly.
- mismatch  output  1  one-cycle pulse: violation detected while LOCKED.
- wrap  output  1  one-cycle pulse: correct wrap transition seen while LOCKED.
- expected  output  WIDTH  predicted next count_in.
- err_count  output  ERR_WIDTH  saturating count of mismatches.

Behaviour:
- All outputs are registered and update on the rising edge where sample_en=1. Visible one cycle after the sample (latency 1).
- Reset:
  - Synchronous; overrides sample_en.
  - state=IDLE, prev=0, match_cnt=0.
  - locked=0, mismatch=0, wrap=0, expected=0, err_count=0.
- Prediction: pred = prev+1 (dir=0) or prev-1 (dir=1), modulo 2^WIDTH. A "match" means count_in == pred.
- sample_en=0: no state, prev, or counter change; mismatch and wrap drop to 0.
- FSM states are IDLE, ACQUIRE, LOCKED. Every accepted sample loads prev<=count_in, and expected<=next prediction from count_in and dir.
- IDLE, on sample: capture; go to ACQUIRE with match_cnt=0. No flags.
- ACQUIRE, on sample:
  - Match: match_cnt+1. When the increment reaches LOCK_COUNT, go to LOCKED and set locked=1.
  - Non-match: match_cnt=0, stay in ACQUIRE, no mismatch pulse, no err_count change.
- LOCKED, on sample:
  - Match: stay. Pulse wrap when count_in == 0 (up) or count_in == all-ones (down).
  - Non-match: pulse mismatch; err_count+1 saturating at 2^ERR_WIDTH-1; locked=0; go to ACQUIRE with match_cnt=0. Resync is from count_in.
- Direction change while LOCKED is a non-match unless count_in equals the new-direction prediction.
- Simultaneous wrap and mismatch is impossible by construction (wrap requires a match).
- Reset mid-sequence discards the in-flight sample entirely.

Optional Feature:
- Macro: COUNT_CHECKER_HOLD_EN.
- Defined: a sample with count_in == prev (counter stalled) is neutral in all states. No match progress, no mismatch, no match_cnt clear, no err_count change; prev and expected are unchanged.
- Not defined: a repeated value is treated as an ordinary non-match.

Test Plan:
- Lock, up mode: rst, then dir=0 samples 0,1,2 → locked=1 after the edge sampling 2, expected=3, err_count=0.
- Up-mode wrap: locked, samples 14,15,0 → wrap=1 for exactly the cycle after sampling 0; mismatch=0, expected=1.
- Error and relock: locked at 5, sample 9 → mismatch pulse 1 cycle, err_count=1, locked=0, expected=10. Then samples 10,11 → locked=1.
- Down mode: dir=1, samples 3,2,1,0,15 → locked after sampling 1. wrap pulse after sampling 15; expected=14.
- Saturation (ERR_WIDTH=2): four lock/violate cycles → err_count 1,2,3,3.
- Reset while locked with sample_en=1 → next cycle all outputs 0, state IDLE. Hold test: locked at 7, sample 7 → mismatch=1 without macro; with macro, no change.
